// File: rtl/rf_rd_arb_if.sv
// Bundle of signals between the register-file read arbiter and its environment.
// The master side is the requesters, the register file and the write bus. The slave side is the arbiter.
interface rf_rd_arb_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_READ  = 2,
    parameter int unsigned NUM_WRITE = 2,
    parameter int unsigned AW        = 5,
    parameter int unsigned DW        = 64
) ();
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*AW-1:0]      req_addr;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [NUM_REQ*DW-1:0]      resp_data;
    logic [NUM_READ-1:0]        rf_re;
    logic [NUM_READ*AW-1:0]     rf_raddr;
    logic [NUM_READ*DW-1:0]     rf_rdata;
    logic [NUM_WRITE-1:0]       we;
    logic [NUM_WRITE*AW-1:0]    waddr;
    logic [NUM_WRITE*DW-1:0]    wdata;

    modport master (
        output req_valid, req_addr, rf_rdata, we, waddr, wdata,
        input  req_ready, resp_valid, resp_data, rf_re, rf_raddr
    );

    modport slave (
        input  req_valid, req_addr, rf_rdata, we, waddr, wdata,
        output req_ready, resp_valid, resp_data, rf_re, rf_raddr
    );
endinterface

// File: rtl/rf_rd_arb.sv
// Round-robin arbiter that maps up to NUM_READ requesters onto register-file read ports.
// It returns each response one cycle later and bypasses same-cycle writes.
module rf_rd_arb #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_READ  = 2,
    parameter int unsigned NUM_WRITE = 2,
    parameter int unsigned AW        = 5,
    parameter int unsigned DW        = 64
) (
    input logic        clk,
    input logic        rst_n,
    rf_rd_arb_if.slave bus
);
    localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PW = (NUM_READ > 1) ? $clog2(NUM_READ) : 1;

    logic [RW-1:0]               ptr_q, ptr_d;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0][PW-1:0]  gnt_port;
    logic [NUM_REQ-1:0]          hit;
    logic [NUM_REQ-1:0][DW-1:0]  hit_data;
    logic [NUM_REQ-1:0]          resp_valid_q;
    logic [NUM_REQ-1:0]          byp_q;
    logic [NUM_REQ-1:0][PW-1:0]  port_q;
    logic [NUM_REQ-1:0][DW-1:0]  byp_data_q;
    int unsigned                 idx;
    int unsigned                 cnt;

    // Scan requesters from ptr_q. Each grant takes the next free read port.
    always_comb begin
        grant         = '0;
        gnt_port      = '0;
        bus.rf_re     = '0;
        bus.rf_raddr  = '0;
        ptr_d         = ptr_q;
        idx           = 0;
        cnt           = 0;
        if (rst_n) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (32'(ptr_q) + k) % NUM_REQ;
                if (bus.req_valid[idx] && (cnt < NUM_READ)) begin
                    grant[idx]                  = 1'b1;
                    gnt_port[idx]               = PW'(cnt);
                    bus.rf_re[cnt]              = 1'b1;
                    bus.rf_raddr[cnt*AW +: AW]  = bus.req_addr[idx*AW +: AW];
                    ptr_d                       = RW'((idx + 1) % NUM_REQ);
                    cnt                         = cnt + 1;
                end
            end
        end
    end

    // The register file returns pre-write data, so a same-cycle write wins. The highest port takes priority.
    always_comb begin
        hit      = '0;
        hit_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_WRITE; j++) begin
                if (bus.we[j] && (bus.waddr[j*AW +: AW] == bus.req_addr[i*AW +: AW])) begin
                    hit[i]      = 1'b1;
                    hit_data[i] = bus.wdata[j*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            resp_valid_q <= '0;
            port_q       <= '0;
            byp_q        <= '0;
            byp_data_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= grant;
            port_q       <= gnt_port;
            byp_q        <= grant & hit;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                byp_data_q[i] <= (grant[i] && hit[i]) ? hit_data[i] : '0;
            end
        end
    end

    always_comb begin
        bus.req_ready  = grant;
        bus.resp_valid = resp_valid_q;
        bus.resp_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (resp_valid_q[i]) begin
                bus.resp_data[i*DW +: DW] = byp_q[i] ? byp_data_q[i]
                                                     : bus.rf_rdata[32'(port_q[i])*DW +: DW];
            end
        end
    end
endmodule

// File: tb/tb_rf_rd_arb.sv
// Directed testbench for rf_rd_arb. A small register-file model supplies the read data.
// The expected values below are worked out by hand.
module tb_rf_rd_arb;
    localparam int unsigned NR = 4;
    localparam int unsigned NP = 2;
    localparam int unsigned NW = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [DW-1:0] rf [32];

    rf_rd_arb_if #(.NUM_REQ(NR), .NUM_READ(NP), .NUM_WRITE(NW), .AW(AW), .DW(DW)) bus ();

    rf_rd_arb #(.NUM_REQ(NR), .NUM_READ(NP), .NUM_WRITE(NW), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: registered read. The read sees the pre-write value and the highest write port wins.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 32; a++) rf[a] <= 64'h1000 + 64'(a);
            rf[7] <= 64'hA5;
        end else begin
            for (int k = 0; k < int'(NP); k++)
                if (bus.rf_re[k]) bus.rf_rdata[k*DW +: DW] <= rf[bus.rf_raddr[k*AW +: AW]];
            for (int j = 0; j < int'(NW); j++)
                if (bus.we[j]) rf[bus.waddr[j*AW +: AW]] <= bus.wdata[j*DW +: DW];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        bus.req_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [63:0] rdata(input int i);
        return bus.resp_data[i*DW +: DW];
    endfunction

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_addr  = '0;
        bus.we        = '0;
        bus.waddr     = '0;
        bus.wdata     = '0;

        // Reset holds every grant low even when all requesters are valid.
        #2;
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_rf_re", 64'(bus.rf_re), 64'h0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        step();
        step();
        check("rst_ready2", 64'(bus.req_ready), 64'h0);
        check("rst_ptr", 64'(dut.ptr_q), 64'h0);
        bus.req_valid = '0;
        rst_n = 1'b1;

        // All four requesters, addresses 1..4.
        set_addr(0, 5'd1); set_addr(1, 5'd2); set_addr(2, 5'd3); set_addr(3, 5'd4);
        bus.req_valid = 4'b1111;
        #1;
        check("c0_ready", 64'(bus.req_ready), 64'b0011);
        check("c0_rf_re", 64'(bus.rf_re), 64'b11);
        check("c0_raddr", 64'(bus.rf_raddr), 64'({5'd2, 5'd1}));
        step();
        check("c1_resp_valid", 64'(bus.resp_valid), 64'b0011);
        check("c1_data0", rdata(0), 64'h1001);
        check("c1_data1", rdata(1), 64'h1002);
        check("c1_ptr", 64'(dut.ptr_q), 64'd2);
        check("c1_ready", 64'(bus.req_ready), 64'b1100);
        check("c1_raddr", 64'(bus.rf_raddr), 64'({5'd4, 5'd3}));
        step();
        check("c2_resp_valid", 64'(bus.resp_valid), 64'b1100);
        check("c2_data2", rdata(2), 64'h1003);
        check("c2_data3", rdata(3), 64'h1004);
        check("c2_data0", rdata(0), 64'h0);
        check("c2_ptr", 64'(dut.ptr_q), 64'd0);
        bus.req_valid = '0;
        #1;
        check("c2_idle_rf_re", 64'(bus.rf_re), 64'h0);
        step();
        check("c3_resp_valid", 64'(bus.resp_valid), 64'h0);

        // Only req3 is valid, reading reg7.
        set_addr(3, 5'd7);
        bus.req_valid = 4'b1000;
        #1;
        check("r3_ready", 64'(bus.req_ready), 64'b1000);
        check("r3_rf_re", 64'(bus.rf_re), 64'b01);
        check("r3_raddr", 64'(bus.rf_raddr), 64'd7);
        step();
        bus.req_valid = '0;
        check("r3_resp_valid", 64'(bus.resp_valid), 64'b1000);
        check("r3_data", rdata(3), 64'hA5);
        check("r3_ptr", 64'(dut.ptr_q), 64'd0);

        // Both write ports hit the read address. The port 1 value must win.
        set_addr(0, 5'd5);
        bus.req_valid = 4'b0001;
        bus.we        = 2'b11;
        bus.waddr     = {5'd5, 5'd5};
        bus.wdata     = {64'h22, 64'h11};
        #1;
        check("byp_ready", 64'(bus.req_ready), 64'b0001);
        step();
        bus.req_valid = '0;
        bus.we        = '0;
        check("byp_resp_valid", 64'(bus.resp_valid), 64'b0001);
        check("byp_data", rdata(0), 64'h22);

        // Move ptr to 3, then test wrap-around with req3 and req0.
        set_addr(2, 5'd6);
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = '0;
        check("wrap_pre_ptr", 64'(dut.ptr_q), 64'd3);
        set_addr(3, 5'd9);
        set_addr(0, 5'd10);
        bus.req_valid = 4'b1001;
        #1;
        check("wrap_ready", 64'(bus.req_ready), 64'b1001);
        check("wrap_rf_re", 64'(bus.rf_re), 64'b11);
        check("wrap_raddr", 64'(bus.rf_raddr), 64'({5'd10, 5'd9}));
        step();
        bus.req_valid = '0;
        check("wrap_ptr", 64'(dut.ptr_q), 64'd1);
        check("wrap_resp_valid", 64'(bus.resp_valid), 64'b1001);
        check("wrap_data3", rdata(3), 64'h1009);
        check("wrap_data0", rdata(0), 64'h100A);
        #1;
        check("idle_rf_re", 64'(bus.rf_re), 64'h0);
        check("idle_raddr", 64'(bus.rf_raddr), 64'h0);
        step();
        check("idle_ptr", 64'(dut.ptr_q), 64'd1);
        check("idle_resp_valid", 64'(bus.resp_valid), 64'h0);

        // Reset asserted while a response is in flight.
        set_addr(1, 5'd3);
        bus.req_valid = 4'b0010;
        #1;
        check("mr_ready", 64'(bus.req_ready), 64'b0010);
        step();
        check("mr_resp_valid_pre", 64'(bus.resp_valid), 64'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("mr_data1", rdata(1), 64'h0);
        check("mr_ptr", 64'(dut.ptr_q), 64'd0);
        check("mr_ready_rst", 64'(bus.req_ready), 64'h0);
        bus.req_valid = '0;
        step();
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        check("post_rst_ptr", 64'(dut.ptr_q), 64'd0);

        // The first arbitration after reset release starts from ptr 0.
        set_addr(1, 5'd11);
        set_addr(2, 5'd12);
        bus.req_valid = 4'b0110;
        #1;
        check("pr_ready", 64'(bus.req_ready), 64'b0110);
        check("pr_raddr", 64'(bus.rf_raddr), 64'({5'd12, 5'd11}));
        step();
        bus.req_valid = '0;
        check("pr_resp_valid", 64'(bus.resp_valid), 64'b0110);
        check("pr_data1", rdata(1), 64'h100B);
        check("pr_data2", rdata(2), 64'h100C);
        check("pr_ptr", 64'(dut.ptr_q), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rf_rd_arb.md
RF_RD_ARB -- requirements
Module: rf_rd_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of read requesters (>=2).
REQ-002 SHALL have parameter NUM_READ, default 2: number of register-file read ports (1..NUM_REQ).
REQ-003 SHALL have parameter NUM_WRITE, default 2: number of register-file write ports observed for bypass.
REQ-004 SHALL have parameter AW, default 5: register address width.
REQ-005 SHALL have parameter DW, default 64: register data width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-007 CLK  in  1  sole clock; all state on rising edge.
REQ-008 RST_N  in  1  asynchronous active-low reset.
REQ-009 REQ_VALID  in  NUM_REQ  per-requester read request.
REQ-010 REQ_ADDR  in  NUM_REQ*AW  per-requester register address; slice i at [i*AW +: AW].
REQ-011 REQ_READY  out  NUM_REQ  grant, combinational, same cycle as request.
REQ-012 RESP_VALID  out  NUM_REQ  registered; read data valid for requester i.
REQ-013 RESP_DATA  out  NUM_REQ*DW  per-requester read data.
REQ-014 RF_RE  out  NUM_READ  register-file read enables.
REQ-015 RF_RADDR  out  NUM_READ*AW  register-file read addresses.
REQ-016 RF_RDATA  in  NUM_READ*DW  register-file read data, registered, valid one cycle after RF_RE.
REQ-017 WE, WADDR, WDATA  in  NUM_WRITE, NUM_WRITE*AW, NUM_WRITE*DW  register-file write bus, snooped only.

Function
REQ-018 Arbiter SHALL scan requesters circularly from pointer PTR and grant the first NUM_READ with REQ_VALID=1 in the same cycle.
REQ-019 The k-th grant in scan order SHALL map to read port k: RF_RE[k]=1, RF_RADDR[k]=REQ_ADDR of that requester.
REQ-020 Unused ports SHALL drive RF_RE=0 and RF_RADDR=0.
REQ-021 REQ_READY[i] SHALL be 1 only if requester i is granted this cycle. REQ_READY SHALL be 0 for all requesters while RST_N=0.
REQ-022 After any grant, PTR SHALL become (index of last granted requester + 1) mod NUM_REQ. With no grant, PTR SHALL hold.
REQ-023 Each grant SHALL store the port index and requester index. The cycle after a grant, RESP_VALID[i]=1 for exactly one cycle (latency 1).
REQ-024 RESP_DATA[i] SHALL be RF_RDATA[port] when RESP_VALID[i]=1, else 0.
REQ-025 Bypass: a granted address matching WADDR[j] with WE[j]=1 in the grant cycle SHALL register WDATA[j] of the highest such j. RESP_DATA SHALL return that value instead of RF_RDATA, because the register file returns the pre-write value.
REQ-026 A requester MAY be granted in consecutive cycles; responses SHALL pipeline with one response per grant, in grant order.
REQ-027 A requester dropping REQ_VALID without a grant SHALL lose nothing; the block SHALL keep no request queue.

Reset
REQ-028 RST_N=0 SHALL immediately clear PTR to 0, RESP_VALID to 0, and all bypass flags and stored port/requester indices, making RESP_DATA 0.
REQ-029 RST_N=0 during a response cycle SHALL discard the in-flight response. Register-file contents are not reset by this block.
REQ-030 The first rising edge after RST_N rises SHALL arbitrate normally from PTR=0.

Verification (NUM_REQ=4, NUM_READ=2, NUM_WRITE=2, AW=5, DW=64)
REQ-031 Bench SHALL cover: after reset, all four requesters valid with addresses 1,2,3,4 -> cycle0: req0 on port0, req1 on port1, PTR=2; cycle1: req2, req3 granted, PTR=0; responses one cycle after each grant.
REQ-032 Bench SHALL cover: only req3 valid, addr 7, reg7=0xA5 -> REQ_READY[3]=1, RF_RE=2'b01, RF_RADDR[0]=7; next cycle RESP_VALID=4'b1000, RESP_DATA[3]=0xA5.
REQ-033 Bench SHALL cover: req0 addr 5 granted with WE=2'b11, WADDR={5,5}, WDATA={0x22,0x11} (port1 = 0x22) -> RESP_DATA[0]=0x22.
REQ-034 Bench SHALL cover: PTR=3, req3 and req0 valid -> port0=req3, port1=req0, PTR=1; idle cycle following -> RF_RE=0, PTR=1 holds.
REQ-035 Bench SHALL cover: RST_N dropped mid-cycle after a grant -> RESP_VALID=0 immediately, no response after release, PTR=0.
